// File: rtl/hub75_capture.sv
// HUB75 panel-side receiver: samples the LED matrix bus in the clk domain and
// replays each latched row pair as a stream of framebuffer pixel writes.
module hub75_capture #(
  parameter int unsigned COLS   = 64,
  parameter int unsigned ROWS   = 32,
  parameter int unsigned ADDR_W = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              panel_clk,
  input  logic              latch,
  input  logic              output_en,
  input  logic              row_sel_a,
  input  logic              row_sel_b,
  input  logic              row_sel_c,
  input  logic              row_sel_d,
  input  logic              red_1,
  input  logic              green_1,
  input  logic              blue_1,
  input  logic              red_2,
  input  logic              green_2,
  input  logic              blue_2,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [ADDR_W-1:0] pix_addr,
  output logic [2:0]        pix_rgb,
  output logic              row_done,
  output logic [15:0]       oe_cycles,
  output logic              overrun,
  output logic              len_err,
  input  logic              status_clr
);

  localparam int unsigned CW        = $clog2(COLS);
  localparam int unsigned BW        = CW + 1;
  localparam int unsigned HALF_ROWS = ROWS / 2;
  localparam logic [CW:0]    COLS_C    = (CW+1)'(COLS);
  localparam logic [BW-1:0]  LAST_BEAT = BW'(2 * COLS - 1);
  // Synchronizers come out of reset with OE inactive so no phantom on-time is counted.
  localparam logic [12:0]    SYNC_RST  = 13'h0400;

  typedef enum logic {ST_IDLE, ST_STREAM} state_e;

  logic [12:0] panel_in_c;
  logic [12:0] sync1_q, sync2_q;
  logic        pclk_prev_q, latch_prev_q;
  logic        pclk_edge_c, latch_edge_c;
  logic        s_oe_n;
  logic [3:0]  s_row;
  logic [2:0]  s_up, s_lo;

  logic [2:0]  shift_up_q [COLS];
  logic [2:0]  shift_lo_q [COLS];
  logic [2:0]  shift_up_d [COLS];
  logic [2:0]  shift_lo_d [COLS];
  logic [2:0]  hold_up_q  [COLS];
  logic [2:0]  hold_lo_q  [COLS];
  logic [CW:0] col_cnt_q, col_cnt_d;

  logic [15:0] oe_cnt_q, oe_cnt_d;
  logic [15:0] oe_cycles_q;
  logic        len_err_q, overrun_q;

  state_e            state_q;
  logic [BW-1:0]     beat_q;
  logic [BW-1:0]     beat_nx_c;
  logic [3:0]        row_q;
  logic              pix_valid_q;
  logic [ADDR_W-1:0] pix_addr_q;
  logic [2:0]        pix_rgb_q;
  logic [2:0]        next_rgb_c;
  logic              row_done_q;
  logic              accept_c, last_c;

  function automatic logic [ADDR_W-1:0] beat_addr(input logic [3:0] row,
                                                  input logic [BW-1:0] beat);
    int unsigned r;
    r = 32'(row) + (beat[CW] ? HALF_ROWS : 32'd0);
    return ADDR_W'(r * COLS + 32'(beat[CW-1:0]));
  endfunction

  assign panel_in_c = {panel_clk, latch, output_en,
                       row_sel_d, row_sel_c, row_sel_b, row_sel_a,
                       red_1, green_1, blue_1, red_2, green_2, blue_2};

  assign pclk_edge_c  = sync2_q[12] & ~pclk_prev_q;
  assign latch_edge_c = sync2_q[11] & ~latch_prev_q;
  assign s_oe_n       = sync2_q[10];
  assign s_row        = sync2_q[9:6];
  assign s_up         = sync2_q[5:3];
  assign s_lo         = sync2_q[2:0];

  // Shift buffer next state; a same-cycle shift lands before a latch copies it.
  always_comb begin
    shift_up_d = shift_up_q;
    shift_lo_d = shift_lo_q;
    col_cnt_d  = col_cnt_q;
    if (pclk_edge_c && (col_cnt_q < COLS_C)) begin
      shift_up_d[col_cnt_q[CW-1:0]] = s_up;
      shift_lo_d[col_cnt_q[CW-1:0]] = s_lo;
      col_cnt_d = col_cnt_q + (CW+1)'(1);
    end
  end

  assign oe_cnt_d = (!s_oe_n && (oe_cnt_q != 16'hFFFF)) ? oe_cnt_q + 16'd1 : oe_cnt_q;

  // Input capture: synchronizers, shift/hold buffers, OE timer, length check.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q      <= SYNC_RST;
      sync2_q      <= SYNC_RST;
      pclk_prev_q  <= 1'b0;
      latch_prev_q <= 1'b0;
      col_cnt_q    <= '0;
      oe_cnt_q     <= '0;
      oe_cycles_q  <= '0;
      len_err_q    <= 1'b0;
      row_q        <= '0;
      for (int i = 0; i < COLS; i++) begin
        shift_up_q[i] <= '0;
        shift_lo_q[i] <= '0;
        hold_up_q[i]  <= '0;
        hold_lo_q[i]  <= '0;
      end
    end else begin
      sync1_q      <= panel_in_c;
      sync2_q      <= sync1_q;
      pclk_prev_q  <= sync2_q[12];
      latch_prev_q <= sync2_q[11];
      if (latch_edge_c) begin
        hold_up_q   <= shift_up_d;
        hold_lo_q   <= shift_lo_d;
        row_q       <= s_row;
        col_cnt_q   <= '0;
        oe_cycles_q <= oe_cnt_d;
        oe_cnt_q    <= '0;
        for (int i = 0; i < COLS; i++) begin
          shift_up_q[i] <= '0;
          shift_lo_q[i] <= '0;
        end
      end else begin
        shift_up_q <= shift_up_d;
        shift_lo_q <= shift_lo_d;
        col_cnt_q  <= col_cnt_d;
        oe_cnt_q   <= oe_cnt_d;
      end
      if (latch_edge_c && (col_cnt_d != COLS_C)) begin
        len_err_q <= 1'b1;
      end else if (status_clr) begin
        len_err_q <= 1'b0;
      end
    end
  end

  assign accept_c   = pix_valid_q & pix_ready;
  assign last_c     = (beat_q == LAST_BEAT);
  assign beat_nx_c  = beat_q + BW'(1);
  assign next_rgb_c = beat_nx_c[CW] ? hold_lo_q[beat_nx_c[CW-1:0]]
                                    : hold_up_q[beat_nx_c[CW-1:0]];

  // Stream FSM; a latch always restarts at beat 0 of the newly captured row.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      beat_q      <= '0;
      pix_valid_q <= 1'b0;
      pix_addr_q  <= '0;
      pix_rgb_q   <= '0;
      row_done_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      row_done_q <= 1'b0;
      if (accept_c && last_c) begin
        row_done_q  <= 1'b1;
        pix_valid_q <= 1'b0;
        state_q     <= ST_IDLE;
      end else if (accept_c) begin
        beat_q     <= beat_nx_c;
        pix_addr_q <= beat_addr(row_q, beat_nx_c);
        pix_rgb_q  <= next_rgb_c;
      end
      if (latch_edge_c) begin
        state_q     <= ST_STREAM;
        beat_q      <= '0;
        pix_valid_q <= 1'b1;
        pix_addr_q  <= beat_addr(s_row, '0);
        pix_rgb_q   <= shift_up_d[0];
      end
      if (latch_edge_c && (state_q == ST_STREAM) && !(accept_c && last_c)) begin
        overrun_q <= 1'b1;
      end else if (status_clr) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign pix_valid = pix_valid_q;
  assign pix_addr  = pix_addr_q;
  assign pix_rgb   = pix_rgb_q;
  assign row_done  = row_done_q;
  assign oe_cycles = oe_cycles_q;
  assign overrun   = overrun_q;
  assign len_err   = len_err_q;

endmodule
